// File: rtl/ela.sv
// Edge-based Line Average de-interlacer for one 32x16 8-bit field.
// Input row k is copied to output row 2k; each missing row 2k+1 is built
// from rows 2k and 2k+2 by picking the direction with the smallest
// absolute difference and averaging that pixel pair.
module ela #(
    parameter int W    = 32,
    parameter int ROWS = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       req,
    input  logic [7:0] in_data,
    output logic       wen,
    output logic [9:0] addr,
    output logic [7:0] data_wr,
    input  logic [7:0] data_rd,
    output logic       done
);

    localparam int DATA_W = 8;
    localparam int COL_W  = $clog2(W);
    localparam int K_W    = $clog2(ROWS);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_RECV   = 2'd1,
        S_INTERP = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [K_W-1:0]     k;
    logic [COL_W-1:0]   col;

    // Line buffers: PREV holds input row k-1, CUR holds input row k.
    logic [DATA_W-1:0]  prev [W];
    logic [DATA_W-1:0]  cur  [W];

    logic [COL_W-1:0]   col_l;
    logic [COL_W-1:0]   col_r;
    logic [DATA_W-1:0]  d1;
    logic [DATA_W-1:0]  d2;
    logic [DATA_W-1:0]  d3;
    logic [DATA_W-1:0]  ela_pix;
    logic [9:0]         row_base;

    // The result memory is write-only from this block's point of view.
    logic unused_rd;
    assign unused_rd = ^data_rd;

    // Floor average of two pixels using a 9-bit sum.
    function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
        logic [DATA_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[DATA_W:1];
    endfunction

    // Absolute difference of two pixels, computed as a signed subtraction.
    function automatic logic [DATA_W-1:0] absdiff(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        logic signed [DATA_W+1:0] d;
        logic [DATA_W-1:0]        r;
        d = $signed({2'b00, x}) - $signed({2'b00, y});
        if (d < 0) begin
            d = -d;
        end
        r = d[DATA_W-1:0];
        return r;
    endfunction

    // 64k+col: the input row k lands on output row 2k (W is 32 so row<<5).
    assign row_base = {k, 1'b0, col};

    // ELA direction choice for the current column; edges fall back to vertical.
    always_comb begin
        col_l   = col - COL_W'(1);
        col_r   = col + COL_W'(1);
        d1      = absdiff(prev[col_l], cur[col_r]);
        d2      = absdiff(prev[col], cur[col]);
        d3      = absdiff(prev[col_r], cur[col_l]);
        ela_pix = avg2(prev[col], cur[col]);
        if (col != '0 && col != COL_W'(W - 1)) begin
            if (d2 <= d1 && d2 <= d3) begin
                ela_pix = avg2(prev[col], cur[col]);
            end else if (d1 <= d3) begin
                ela_pix = avg2(prev[col_l], cur[col_r]);
            end else begin
                ela_pix = avg2(prev[col_r], cur[col_l]);
            end
        end
    end

    // Line buffer capture and the CUR->PREV hand-over at the end of each row.
    always_ff @(posedge clk) begin
        if (state == S_RECV) begin
            cur[col] <= in_data;
            if (col == COL_W'(W - 1) && k == '0) begin
                for (int i = 0; i < W; i++) begin
                    prev[i] <= cur[i];
                end
                // Column 31 is being sampled on this very edge.
                prev[W-1] <= in_data;
            end
        end else if (state == S_INTERP && col == COL_W'(W - 1)) begin
            for (int i = 0; i < W; i++) begin
                prev[i] <= cur[i];
            end
        end
    end

    // Control FSM with registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_REQ;
            k       <= '0;
            col     <= '0;
            req     <= 1'b0;
            wen     <= 1'b0;
            addr    <= '0;
            data_wr <= '0;
            done    <= 1'b0;
        end else begin
            req <= 1'b0;
            wen <= 1'b0;
            case (state)
                S_REQ: begin
                    req   <= 1'b1;
                    col   <= '0;
                    state <= S_RECV;
                end
                S_RECV: begin
                    wen     <= 1'b1;
                    addr    <= row_base;
                    data_wr <= in_data;
                    col     <= col + COL_W'(1);
                    if (col == COL_W'(W - 1)) begin
                        col <= '0;
                        if (k == '0) begin
                            k     <= K_W'(1);
                            state <= S_REQ;
                        end else begin
                            state <= S_INTERP;
                        end
                    end
                end
                S_INTERP: begin
                    wen     <= 1'b1;
                    // 32*(2k-1)+col == 64k+col-32
                    addr    <= row_base - 10'd32;
                    data_wr <= ela_pix;
                    col     <= col + COL_W'(1);
                    if (col == COL_W'(W - 1)) begin
                        col <= '0;
                        if (k == K_W'(ROWS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            k     <= k + K_W'(1);
                            state <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ela.sv
// Scoreboard bench for the ELA de-interlacer: the row driver pushes the
// expected memory writes, a negedge monitor pops and compares them.
module tb_ela;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req;
    logic [7:0] in_data = 8'h00;
    logic       wen;
    logic [9:0] addr;
    logic [7:0] data_wr;
    logic [7:0] data_rd = 8'h00;
    logic       done;

    ela dut (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .wen(wen),
        .addr(addr), .data_wr(data_wr), .data_rd(data_rd), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] frame [16][32];
    logic [7:0] mem   [1024];
    int         checks  = 0;
    int         errors  = 0;
    int         nwrites = 0;
    bit         mon_en  = 0;
    bit         prev_wen = 0;
    logic [9:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference interpolation between input rows r (above) and r+1 (below).
    function automatic logic [7:0] ref_ela(input int r, input int c);
        int d [3];
        int s [3];
        int best;
        if (c == 0 || c == 31) begin
            return 8'((int'(frame[r][c]) + int'(frame[r+1][c])) / 2);
        end
        // Candidate order doubles as tie priority: vertical, D1, D3.
        s[0] = int'(frame[r][c])   + int'(frame[r+1][c]);
        d[0] = int'(frame[r][c])   - int'(frame[r+1][c]);
        s[1] = int'(frame[r][c-1]) + int'(frame[r+1][c+1]);
        d[1] = int'(frame[r][c-1]) - int'(frame[r+1][c+1]);
        s[2] = int'(frame[r][c+1]) + int'(frame[r+1][c-1]);
        d[2] = int'(frame[r][c+1]) - int'(frame[r+1][c-1]);
        for (int i = 0; i < 3; i++) begin
            if (d[i] < 0) d[i] = -d[i];
        end
        best = 0;
        for (int i = 1; i < 3; i++) begin
            if (d[i] < d[best]) best = i;
        end
        return 8'(s[best] / 2);
    endfunction

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_wen = 0;
        end else begin
            if (prev_wen && prev_addr[4:0] != 5'd31) begin
                check("row_no_gap", {31'd0, wen}, 32'd1);
            end
            if (wen) begin
                nwrites++;
                check("addr_range", {31'd0, (addr <= 10'd991)}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {22'd0, addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("write_addr", {22'd0, addr}, {22'd0, e.a});
                    check("write_data", {24'd0, data_wr}, {24'd0, e.d});
                end
                mem[addr] = data_wr;
            end
            prev_wen  = wen;
            prev_addr = addr;
        end
    end

    task automatic do_reset();
        mon_en = 0;
        rst    = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_req",  {31'd0, req},  32'd0);
        check("rst_wen",  {31'd0, wen},  32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {22'd0, addr}, 32'd0);
        check("rst_data", {24'd0, data_wr}, 32'd0);
        for (int i = 0; i < 1024; i++) mem[i] = 8'hAA;
        nwrites = 0;
        rst    = 1'b0;
        mon_en = 1;
    endtask

    task automatic wait_req(output bit ok);
        int t;
        t = 0;
        while (req !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = (req === 1'b1);
        if (!ok) check("req_timeout", {31'd0, req}, 32'd1);
    endtask

    task automatic feed_row(input int k, output bit ok);
        wait_req(ok);
        if (!ok) return;
        for (int c = 0; c < 32; c++) begin
            exp_q.push_back('{a: 10'(64 * k + c), d: frame[k][c]});
        end
        if (k > 0) begin
            for (int c = 0; c < 32; c++) begin
                exp_q.push_back('{a: 10'(32 * (2 * k - 1) + c), d: ref_ela(k - 1, c)});
            end
        end
        for (int c = 0; c < 32; c++) begin
            in_data = frame[k][c];
            @(negedge clk);
            if (c == 0) check("req_one_cycle", {31'd0, req}, 32'd0);
        end
    endtask

    task automatic run_frame();
        bit ok;
        int t;
        for (int k = 0; k < 16; k++) begin
            feed_row(k, ok);
            if (!ok) return;
        end
        t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_rise", {31'd0, done}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        check("write_count", nwrites, 32'd992);
        repeat (5) @(negedge clk);
        check("done_held", {31'd0, done}, 32'd1);
        check("wen_idle",  {31'd0, wen},  32'd0);
        check("req_idle",  {31'd0, req},  32'd0);
    endtask

    initial begin
        int bad;
        bit ok;

        // Flat field
        do_reset();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++) frame[r][c] = 8'h40;
        run_frame();
        bad = 0;
        for (int i = 0; i < 992; i++) if (mem[i] !== 8'h40) bad++;
        check("flat_image_bad_bytes", bad, 32'd0);

        // Alternating black / white rows
        do_reset();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++) frame[r][c] = (r % 2 == 0) ? 8'h00 : 8'hFF;
        run_frame();
        bad = 0;
        for (int i = 0; i < 992; i++) begin
            int orow;
            orow = i / 32;
            if (orow % 2 == 1) begin
                if (mem[i] !== 8'h7F) bad++;
            end else if (mem[i] !== (((orow / 2) % 2 == 0) ? 8'h00 : 8'hFF)) begin
                bad++;
            end
        end
        check("alt_image_bad_bytes", bad, 32'd0);

        // Directed edge patterns, with an aborted frame in front
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++) frame[r][c] = 8'((r * 53 + c * 29 + r * c) & 255);
        frame[0][9] = 8'd10;  frame[0][10] = 8'd50;  frame[0][11] = 8'd90;
        frame[1][9] = 8'd90;  frame[1][10] = 8'd50;  frame[1][11] = 8'd10;
        frame[2][9] = 8'd100; frame[2][10] = 8'd0;   frame[2][11] = 8'd0;
        frame[3][9] = 8'd0;   frame[3][10] = 8'd200; frame[3][11] = 8'd100;
        frame[4][0] = 8'd3;   frame[5][0] = 8'd6;

        do_reset();
        mon_en = 0;
        wait_req(ok);
        for (int c = 0; c < 10; c++) begin
            in_data = frame[0][c];
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_req",  {31'd0, req},  32'd0);
        check("abort_wen",  {31'd0, wen},  32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        do_reset();
        run_frame();

        check("tie_vertical_col10", {24'd0, mem[1 * 32 + 10]}, 32'd50);
        check("diag_d1_col10",      {24'd0, mem[5 * 32 + 10]}, 32'd100);
        check("left_edge_col0",     {24'd0, mem[9 * 32 + 0]},  32'd4);
        check("input_row2_col10",   {24'd0, mem[4 * 32 + 10]}, 32'd0);
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 32; c++) begin
                if (mem[64 * r + c] !== frame[r][c]) bad++;
                if (r < 15 && mem[32 * (2 * r + 1) + c] !== ref_ela(r, c)) bad++;
            end
        end
        check("pattern_image_bad_bytes", bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
